// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD test-pattern colour stage.
// Holds the panel geometry defaults, pattern encodings and RGB565 colour constants.
package lcd_pkg;

    localparam int unsigned DEF_H_ACTIVE        = 480;
    localparam int unsigned DEF_V_ACTIVE        = 272;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 90000;

    localparam int unsigned R_W = 5;
    localparam int unsigned G_W = 6;
    localparam int unsigned B_W = 5;

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_GRAD   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_BORDER = 2'd3
    } mode_e;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    localparam rgb565_t RGB_WHITE   = '{r: 5'd31, g: 6'd63, b: 5'd31};
    localparam rgb565_t RGB_YELLOW  = '{r: 5'd31, g: 6'd63, b: 5'd0};
    localparam rgb565_t RGB_CYAN    = '{r: 5'd0,  g: 6'd63, b: 5'd31};
    localparam rgb565_t RGB_GREEN   = '{r: 5'd0,  g: 6'd63, b: 5'd0};
    localparam rgb565_t RGB_MAGENTA = '{r: 5'd31, g: 6'd0,  b: 5'd31};
    localparam rgb565_t RGB_RED     = '{r: 5'd31, g: 6'd0,  b: 5'd0};
    localparam rgb565_t RGB_BLUE    = '{r: 5'd0,  g: 6'd0,  b: 5'd31};
    localparam rgb565_t RGB_BLACK   = '{r: 5'd0,  g: 6'd0,  b: 5'd0};

    // Colour-bar palette, left to right.
    function automatic rgb565_t bar_colour(input logic [2:0] idx);
        rgb565_t c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

    function automatic mode_e mode_next(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// LCD pixel path: timing-generator inputs and the delayed/coloured pin outputs.
interface lcd_pattern_gen_if;
    import lcd_pkg::*;

    logic           LCD_DE_in;
    logic           LCD_HSYNC_in;
    logic           LCD_VSYNC_in;
    logic           LCD_DE;
    logic           LCD_HSYNC;
    logic           LCD_VSYNC;
    logic [R_W-1:0] LCD_R;
    logic [G_W-1:0] LCD_G;
    logic [B_W-1:0] LCD_B;

    modport master (
        output LCD_DE_in, LCD_HSYNC_in, LCD_VSYNC_in,
        input  LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B
    );

    modport slave (
        input  LCD_DE_in, LCD_HSYNC_in, LCD_VSYNC_in,
        output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus debounce counter for an active-low push button.
// Emits a one-cycle press pulse on each accepted 1->0 transition of the stable level.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 90000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Count only while the synced level disagrees with the accepted level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            press_d  = ~sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/lcd_pattern_gen.sv
// Pixel-colour stage: tracks x/y from DE/HSYNC/VSYNC and renders one of four test
// patterns as RGB565, keeping sync/DE aligned with colour through a 2-stage pipeline.
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic             PixelClk,
    input  logic             nRST,
    input  logic             User_Button,
    lcd_pattern_gen_if.slave lcd,
    output logic [1:0]       mode
);

    // Gradient and checker slices reach bit 8, so keep at least 9 bits.
    localparam int unsigned XW = ($clog2(H_ACTIVE) > 9) ? $clog2(H_ACTIVE) : 9;
    localparam int unsigned YW = ($clog2(V_ACTIVE) > 9) ? $clog2(V_ACTIVE) : 9;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic          press;

    logic [XW-1:0] xcnt_q, xcnt_d;
    logic [YW-1:0] ycnt_q, ycnt_d;
    logic [XW-1:0] px_x_q;
    logic [YW-1:0] px_y_q;
    logic          de1_q, hs1_q, vs1_q;
    mode_e         mode_q, mode_d;
    mode_e         pend_q, pend_d;

    logic          de2_q, hs2_q, vs2_q;
    rgb565_t       rgb_q, rgb_d;

    logic [2:0]    bar;
    rgb565_t       pix;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_debounce (
        .clk    (PixelClk),
        .rst_n  (nRST),
        .btn_i  (User_Button),
        .press_o(press)
    );

    // Pixel counters and mode bookkeeping; VSYNC low both clears y and commits the mode.
    always_comb begin
        xcnt_d = '0;
        if (lcd.LCD_DE_in) begin
            xcnt_d = (xcnt_q == X_LAST) ? xcnt_q : xcnt_q + 1'b1;
        end

        ycnt_d = ycnt_q;
        if (!lcd.LCD_VSYNC_in) begin
            ycnt_d = '0;
        end else if (de1_q && !lcd.LCD_DE_in && (ycnt_q != Y_LAST)) begin
            ycnt_d = ycnt_q + 1'b1;
        end

        pend_d = press ? mode_next(pend_q) : pend_q;
        mode_d = lcd.LCD_VSYNC_in ? mode_q : pend_q;
    end

    // Stage 1: sync/DE, pixel index and applied mode.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            xcnt_q <= '0;
            ycnt_q <= '0;
            px_x_q <= '0;
            px_y_q <= '0;
            de1_q  <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            mode_q <= MODE_BARS;
            pend_q <= MODE_BARS;
        end else begin
            xcnt_q <= xcnt_d;
            ycnt_q <= ycnt_d;
            px_x_q <= xcnt_q;
            px_y_q <= ycnt_q;
            de1_q  <= lcd.LCD_DE_in;
            hs1_q  <= lcd.LCD_HSYNC_in;
            vs1_q  <= lcd.LCD_VSYNC_in;
            mode_q <= mode_d;
            pend_q <= pend_d;
        end
    end

    // Pattern renderer; bar index from threshold compares rather than a divide.
    always_comb begin
        bar = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (32'(px_x_q) >= i * BAR_W) begin
                bar = 3'(i);
            end
        end

        pix = RGB_BLACK;
        case (mode_q)
            MODE_BARS: begin
                pix = bar_colour(bar);
            end
            MODE_GRAD: begin
                pix.r = px_x_q[8:4];
                pix.g = px_y_q[8:3];
                pix.b = 5'd31 - px_x_q[8:4];
            end
            MODE_CHECK: begin
                pix = (px_x_q[4] ^ px_y_q[4]) ? RGB_WHITE : RGB_BLACK;
            end
            MODE_BORDER: begin
                pix = ((px_x_q == '0) || (px_x_q == X_LAST) ||
                       (px_y_q == '0) || (px_y_q == Y_LAST)) ? RGB_WHITE : RGB_BLUE;
            end
            default: pix = RGB_BLACK;
        endcase

        rgb_d = de1_q ? pix : RGB_BLACK;
    end

    // Stage 2: colour and the second sync/DE copy.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de2_q <= 1'b0;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
            rgb_q <= RGB_BLACK;
        end else begin
            de2_q <= de1_q;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            rgb_q <= rgb_d;
        end
    end

    assign lcd.LCD_DE    = de2_q;
    assign lcd.LCD_HSYNC = hs2_q;
    assign lcd.LCD_VSYNC = vs2_q;
    assign lcd.LCD_R     = rgb_q.r;
    assign lcd.LCD_G     = rgb_q.g;
    assign lcd.LCD_B     = rgb_q.b;
    assign mode          = mode_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Self-checking bench for lcd_pattern_gen: streams lines/frames, predicts pins via a
// scoreboard queue, and probes specific pixels from a table across all four patterns.
module tb_lcd_pattern_gen;

    localparam logic [15:0] C_WHITE   = 16'hFFFF;
    localparam logic [15:0] C_YELLOW  = 16'hFFE0;
    localparam logic [15:0] C_CYAN    = 16'h07FF;
    localparam logic [15:0] C_GREEN   = 16'h07E0;
    localparam logic [15:0] C_MAGENTA = 16'hF81F;
    localparam logic [15:0] C_RED     = 16'hF800;
    localparam logic [15:0] C_BLUE    = 16'h001F;
    localparam logic [15:0] C_BLACK   = 16'h0000;
    localparam int NPROBE = 23;

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] rgb;
    } exp_t;

    typedef struct {
        int          m;
        int          x;
        int          y;
        logic [15:0] rgb;
    } probe_t;

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic [1:0] mode;

    int     n_checks;
    int     n_fail;
    int     cyc;
    int     pend_exp;
    int     mode_exp;
    exp_t   sb[$];
    probe_t tbl[NPROBE];

    lcd_pattern_gen_if lcd();

    lcd_pattern_gen #(
        .H_ACTIVE       (480),
        .V_ACTIVE       (272),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .PixelClk   (clk),
        .nRST       (rst_n),
        .User_Button(btn),
        .lcd        (lcd),
        .mode       (mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] pack565(input int r, input int g, input int b);
        return {5'(r), 6'(g), 5'(b)};
    endfunction

    function automatic logic [15:0] ref_rgb(input int m, input int x, input int y);
        if (m == 0) begin
            case (x / 60)
                0: return C_WHITE;
                1: return C_YELLOW;
                2: return C_CYAN;
                3: return C_GREEN;
                4: return C_MAGENTA;
                5: return C_RED;
                6: return C_BLUE;
                default: return C_BLACK;
            endcase
        end else if (m == 1) begin
            return pack565((x / 16) % 32, (y / 8) % 64, 31 - ((x / 16) % 32));
        end else if (m == 2) begin
            return ((((x / 16) + (y / 16)) % 2) == 1) ? C_WHITE : C_BLACK;
        end
        return (x == 0 || x == 479 || y == 0 || y == 271) ? C_WHITE : C_BLUE;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Drive one input cycle, queue its prediction, compare the pins 2 edges later.
    task automatic drive(input logic de, input logic hs, input logic vs, input logic [15:0] rgb);
        exp_t e;
        exp_t o;
        lcd.LCD_DE_in    = de;
        lcd.LCD_HSYNC_in = hs;
        lcd.LCD_VSYNC_in = vs;
        e.de  = de;
        e.hs  = hs;
        e.vs  = vs;
        e.rgb = de ? rgb : C_BLACK;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() >= 2) begin
            o = sb.pop_front();
            chk("pipe", 32'({lcd.LCD_DE, lcd.LCD_HSYNC, lcd.LCD_VSYNC, lcd.LCD_R, lcd.LCD_G, lcd.LCD_B}),
                32'({o.de, o.hs, o.vs, o.rgb}));
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 1'b1, C_BLACK);
    endtask

    task automatic vsync();
        repeat (3) drive(1'b0, 1'b1, 1'b0, C_BLACK);
        repeat (2) idle();
    endtask

    // One line: hsync, back porch, npix active pixels, front porch; pixel tx expects trgb.
    task automatic line(input int y, input int npix, input int m, input int tx, input logic [15:0] trgb);
        repeat (2) drive(1'b0, 1'b0, 1'b1, C_BLACK);
        repeat (2) idle();
        for (int c = 0; c < npix; c++) begin
            drive(1'b1, 1'b1, 1'b1, (c == tx) ? trgb : ref_rgb(m, c, y));
        end
        repeat (2) idle();
    endtask

    task automatic press();
        btn = 1'b0;
        repeat (14) idle();
        btn = 1'b1;
        repeat (14) idle();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_de"}, 32'(lcd.LCD_DE), 32'd0);
        chk({tag, "_hs"}, 32'(lcd.LCD_HSYNC), 32'd1);
        chk({tag, "_vs"}, 32'(lcd.LCD_VSYNC), 32'd1);
        chk({tag, "_rgb"}, 32'({lcd.LCD_R, lcd.LCD_G, lcd.LCD_B}), 32'd0);
        chk({tag, "_mode"}, 32'(mode), 32'd0);
    endtask

    task automatic restart_scoreboard();
        exp_t r;
        sb.delete();
        r.de  = 1'b0;
        r.hs  = 1'b1;
        r.vs  = 1'b1;
        r.rgb = C_BLACK;
        sb.push_back(r);
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 16'h001F};
        tbl[1]  = '{1, 479, 20, 16'hE842};
        tbl[2]  = '{1, 100, 40, 16'h30B9};
        tbl[3]  = '{2, 15, 0, C_BLACK};
        tbl[4]  = '{2, 16, 0, C_WHITE};
        tbl[5]  = '{2, 16, 16, C_BLACK};
        tbl[6]  = '{2, 0, 16, C_WHITE};
        tbl[7]  = '{3, 0, 5, C_WHITE};
        tbl[8]  = '{3, 479, 5, C_WHITE};
        tbl[9]  = '{3, 5, 0, C_WHITE};
        tbl[10] = '{3, 5, 271, C_WHITE};
        tbl[11] = '{3, 5, 5, C_BLUE};
        tbl[12] = '{3, 478, 270, C_BLUE};
        tbl[13] = '{3, 479, 271, C_WHITE};
        tbl[14] = '{0, 59, 0, C_WHITE};
        tbl[15] = '{0, 60, 0, C_YELLOW};
        tbl[16] = '{0, 120, 2, C_CYAN};
        tbl[17] = '{0, 180, 0, C_GREEN};
        tbl[18] = '{0, 240, 0, C_MAGENTA};
        tbl[19] = '{0, 300, 0, C_RED};
        tbl[20] = '{0, 419, 0, C_BLUE};
        tbl[21] = '{0, 420, 0, C_BLACK};
        tbl[22] = '{0, 479, 0, C_BLACK};

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        pend_exp = 0;
        mode_exp = 0;
        btn      = 1'b1;
        rst_n    = 1'b1;
        lcd.LCD_DE_in    = 1'b0;
        lcd.LCD_HSYNC_in = 1'b1;
        lcd.LCD_VSYNC_in = 1'b1;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("init");
        rst_n = 1'b1;
        restart_scoreboard();

        // Colour bars across a full line.
        vsync();
        chk("mode_start", 32'(mode), 32'd0);
        line(0, 480, 0, -1, C_BLACK);

        // Bounces, one clean press, then a too-short low: exactly one increment, held mid-frame.
        for (int b = 0; b < 3; b++) begin
            btn = 1'b0;
            repeat (3) idle();
            btn = 1'b1;
            repeat (3) idle();
        end
        press();
        btn = 1'b0;
        repeat (7) idle();
        btn = 1'b1;
        repeat (14) idle();
        pend_exp = 1;
        chk("mode_hold", 32'(mode), 32'd0);
        line(1, 480, 0, -1, C_BLACK);
        chk("mode_hold2", 32'(mode), 32'd0);
        vsync();
        mode_exp = 1;
        chk("mode_commit", 32'(mode), 32'd1);
        line(0, 480, 1, -1, C_BLACK);

        // Pixel probes; mode changes by pressing until the pending mode matches.
        for (int i = 0; i < NPROBE; i++) begin
            while (pend_exp != tbl[i].m) begin
                press();
                pend_exp = (pend_exp + 1) % 4;
            end
            vsync();
            mode_exp = pend_exp;
            chk("probe_mode", 32'(mode), 32'(mode_exp));
            for (int r = 0; r < tbl[i].y; r++) begin
                line(r, 1, mode_exp, -1, C_BLACK);
            end
            line(tbl[i].y, tbl[i].x + 1, mode_exp, tbl[i].x, tbl[i].rgb);
        end

        // Border frame with an extra line beyond the last row.
        repeat (3) press();
        pend_exp = 3;
        vsync();
        mode_exp = 3;
        chk("mode_border", 32'(mode), 32'd3);
        line(0, 480, 3, -1, C_BLACK);
        for (int r = 1; r < 271; r++) begin
            line(r, 3, 3, -1, C_BLACK);
        end
        line(271, 480, 3, -1, C_BLACK);
        line(271, 480, 3, 479, C_WHITE);

        // Reset in the middle of an active line.
        repeat (2) drive(1'b0, 1'b0, 1'b1, C_BLACK);
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b1, 1'b1, ref_rgb(3, c, 271));
        end
        #2 rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        @(posedge clk);
        #1;
        chk_reset("held_rst");
        rst_n = 1'b1;
        restart_scoreboard();
        pend_exp = 0;
        mode_exp = 0;
        drive(1'b1, 1'b1, 1'b1, C_WHITE);
        drive(1'b0, 1'b1, 1'b1, C_BLACK);
        drive(1'b1, 1'b1, 1'b1, C_WHITE);
        drive(1'b1, 1'b1, 1'b1, C_WHITE);
        drive(1'b0, 1'b0, 1'b1, C_BLACK);
        repeat (2) idle();
        vsync();
        chk("mode_after_rst", 32'(mode), 32'd0);
        line(0, 480, 0, -1, C_BLACK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_pattern_gen.md
# lcd_pattern_gen

Pixel-colour stage for the 4.3" 480x272 RGB LCD path, directly downstream of the sync/DE timing generator and driving the LCD pins. It tracks pixel x/y from the incoming DE/HSYNC/VSYNC stream and renders one of four test patterns as RGB565. It delays the sync/DE signals so they stay cycle-aligned with the colour data. The on-board User_Button, debounced internally, steps the pattern; a new pattern takes effect only at a frame boundary.

## Interface
- H_ACTIVE, 480: active pixels per line.
- V_ACTIVE, 272: active lines per frame.
- DEBOUNCE_CYCLES, 90000: stable-input cycles required before a button level is accepted (10 ms at 9 MHz).
- PixelClk  in  1  pixel clock (9 MHz); the only clock.
- nRST  in  1  asynchronous, active-low reset.
- User_Button  in  1  raw push button; active-low, asynchronous to PixelClk.
- LCD_DE_in, LCD_HSYNC_in, LCD_VSYNC_in  in  1 each  from the timing generator; DE is active-high, syncs are active-low.
- LCD_DE, LCD_HSYNC, LCD_VSYNC  out  1 each  the inputs delayed by 2 cycles.
- LCD_R  out  5, LCD_G  out  6, LCD_B  out  5  pixel colour.
- mode  out  2  currently applied pattern.

## Operation
- **x counter:** 0 while LCD_DE_in=0; +1 per cycle with DE=1, saturating at H_ACTIVE-1. The current pixel index is the pre-increment value.
- **y counter:**
  - Cleared while LCD_VSYNC_in=0.
  - Otherwise +1 on each DE falling edge (registered DE=1, input DE=0), saturating at V_ACTIVE-1.
  - If both conditions hold in the same cycle, the clear wins.
- **Button path:**
  - Two-flop synchronizer feeds the debouncer.
  - The counter resets whenever the synced level equals the stable level. Otherwise it counts; when it reaches DEBOUNCE_CYCLES-1 the stable level takes the synced level and the counter clears.
  - A stable 1->0 transition is one press. Each press sets pending_mode = pending_mode+1, wrapping 3->0.
  - Releases and bounces produce no event.
- **Mode commit:** mode <= pending_mode on every cycle with LCD_VSYNC_in=0, so a frame never changes pattern mid-frame. A press during VSYNC low commits on the next VSYNC-low cycle.
- **Patterns** (x,y = pixel index), RGB as R/G/B values:
  - **0, colour bars:** 8 bars of H_ACTIVE/8 px. Order: white(31,63,31), yellow(31,63,0), cyan(0,63,31), green(0,63,0), magenta(31,0,31), red(31,0,0), blue(0,0,31), black(0,0,0). Bar index uses comparisons, not a divider.
  - **1, gradient:** R=x[8:4], G=y[8:3], B=31-x[8:4].
  - **2, checkerboard:** 16 px squares. White when x[4]^y[4]=1, else black.
  - **3, border:** white when x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1; otherwise blue(0,0,31).
- **Blanking:** RGB is forced to 0 whenever the delayed DE is 0.

## Timing
- **Pipeline:**
  - Stage 1 registers DE/HS/VS, x, y and mode.
  - Stage 2 registers the colour and a second copy of DE/HS/VS.
  - Total latency is 2 cycles from input to pins for every output.
  - There is no back-pressure; one pixel is accepted per cycle.
- **Reset values:**
  - LCD_DE=0, LCD_HSYNC=1, LCD_VSYNC=1, RGB=0.
  - mode=0, pending_mode=0.
  - x=y=0.
  - Stable button level=1; synchronizer flops=1; debounce counter=0.
- **Reset mid-frame:** outputs return to reset values immediately. After release, counts restart from the next DE/VSYNC. Garbage y is tolerated until the first VSYNC-low.
- **Button latency:** a press is registered 2 sync cycles plus DEBOUNCE_CYCLES after the level settles.

## Structure
- **Package lcd_pkg:**
  - H_ACTIVE/V_ACTIVE defaults.
  - Mode encodings MODE_BARS=0, MODE_GRAD=1, MODE_CHECK=2, MODE_BORDER=3.
  - RGB565 colour constants (white, yellow, cyan, green, magenta, red, blue, black).
- **Sub-module button_debounce** (synchronizer plus debounce counter) outputs a one-cycle press pulse and is reusable for Reset/other buttons. The pattern logic stays in this block.

## Test plan
- Reset asserted mid-line with DE=1 -> all outputs at reset values on the same edge. After release, LCD_DE follows LCD_DE_in exactly 2 cycles later.
- Mode 0, one 480-px line -> pins 0..59 white, 60..119 yellow, ... 420..479 black. RGB=0 in the cycles where LCD_DE=0.
- Mode 2 -> pixel (15,0) white? No: x[4]=0, y[4]=0 -> black. Pixel (16,0) -> white. Pixel (16,16) -> black.
- DEBOUNCE_CYCLES=8; 3 bounces of 3 cycles each, then a stable low -> exactly one pending increment. A low held for only 7 cycles -> no increment.
- Press mid-frame -> mode and pixel colours unchanged until VSYNC goes low, then mode=1. Four presses total -> mode wraps back to 0.
- Mode 3, full frame -> white at rows 0 and 271 and at columns 0 and 479; blue elsewhere. The y counter saturates at 271 if extra DE lines arrive.
